// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// buffers the returned word for decode. Handles redirects and halt.
module ifu_fetch #(
  parameter int unsigned          XLEN   = 32,
  parameter logic [XLEN-1:0]      PC_RST = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            ifu_inst_valid,
  input  logic            ifu_inst_ready,
  output logic [XLEN-1:0] ifu_inst,
  output logic [XLEN-1:0] ifu_pc,
  input  logic            exu_redirect,
  input  logic [XLEN-1:0] exu_redirect_pc,
  input  logic            ifu_halt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            req_valid_q;
  logic            inst_valid_q;

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_inc;
  state_t          after_state;

  assign redirect_tgt = {exu_redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc       = pc_q + XLEN'(4);
  assign after_state  = ifu_halt ? IDLE : REQ;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      IDLE: begin
        if (exu_redirect) pc_d = redirect_tgt;
        if (!ifu_halt) state_d = REQ;
      end
      REQ: begin
        if (exu_redirect) pc_d = redirect_tgt;
        // An accepted request that collides with a redirect still owes a
        // response; mark it so that response is thrown away.
        if (imem_req_ready) begin
          state_d = WAIT;
          drop_d  = exu_redirect;
        end else if (ifu_halt) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (exu_redirect) begin
            pc_d    = redirect_tgt;
            drop_d  = 1'b0;
            state_d = after_state;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = after_state;
          end else begin
            inst_d  = imem_rsp_data;
            ipc_d   = pc_q;
            state_d = VALID;
          end
        end else if (exu_redirect) begin
          pc_d   = redirect_tgt;
          drop_d = 1'b1;
        end
      end
      VALID: begin
        if (exu_redirect) begin
          pc_d    = redirect_tgt;
          state_d = after_state;
        end else if (ifu_inst_ready) begin
          pc_d    = pc_inc;
          state_d = after_state;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      pc_q         <= PC_RST;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      ipc_q        <= PC_RST;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      ipc_q        <= ipc_d;
      req_valid_q  <= (state_d == REQ);
      inst_valid_q <= (state_d == VALID);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign ifu_inst_valid = inst_valid_q;
  assign ifu_inst       = inst_q;
  assign ifu_pc         = ipc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run checked against
// an instruction-stream model (expected PC sequence and address-keyed memory).
module tb_ifu_fetch;

  localparam logic [31:0] PC_RST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifu_inst_valid;
  logic        ifu_inst_ready;
  logic [31:0] ifu_inst;
  logic [31:0] ifu_pc;
  logic        exu_redirect;
  logic [31:0] exu_redirect_pc;
  logic        ifu_halt;

  int tests_run    = 0;
  int tests_failed = 0;

  ifu_fetch #(.XLEN(32), .PC_RST(PC_RST)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .ifu_inst_valid  (ifu_inst_valid),
    .ifu_inst_ready  (ifu_inst_ready),
    .ifu_inst        (ifu_inst),
    .ifu_pc          (ifu_pc),
    .exu_redirect    (exu_redirect),
    .exu_redirect_pc (exu_redirect_pc),
    .ifu_halt        (ifu_halt)
  );

  always #5 clk = ~clk;

  // Memory contents are a bijection of the address, so a stale word paired
  // with a new PC can never look correct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    ifu_inst_ready  = 1'b0;
    exu_redirect    = 1'b0;
    exu_redirect_pc = '0;
    ifu_halt        = 1'b0;
  endtask

  // Leaves the DUT in the first cycle after reset release (IDLE).
  task automatic do_reset;
    rst_b = 1'b0;
    clear_inputs;
    tick;
    tick;
    rst_b = 1'b1;
  endtask

  // From a REQ cycle: accept the request, answer next cycle, land in VALID.
  task automatic fetch_to_valid(input logic [31:0] d);
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    tick;
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    clear_inputs;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick;
    tick;
    tests_run++;
    if ({imem_req_valid, ifu_inst_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_valids: got %b expected 00", {imem_req_valid, ifu_inst_valid});
    end
    tests_run++;
    if (ifu_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_inst: got %h expected 00000000", ifu_inst);
    end
    tests_run++;
    if (ifu_pc !== PC_RST || imem_req_addr !== PC_RST) begin
      tests_failed++;
      $display("FAIL reset_pc: got pc %h addr %h expected %h", ifu_pc, imem_req_addr, PC_RST);
    end
    imem_rsp_valid = 1'b0;
    rst_b = 1'b1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cycle0_req: got %b expected 0", imem_req_valid);
    end
  endtask

  task automatic test_basic;
    do_reset;
    tick;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL basic_req1: got v=%b addr %h expected v=1 addr 80000000", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    tests_run++;
    if ({imem_req_valid, ifu_inst_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL basic_wait: got %b expected 00", {imem_req_valid, ifu_inst_valid});
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    tick;
    imem_rsp_valid = 1'b0;
    tests_run++;
    if (ifu_inst_valid !== 1'b1 || ifu_inst !== 32'h0010_0093 || ifu_pc !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL basic_inst: got v=%b inst %h pc %h expected v=1 inst 00100093 pc 80000000",
               ifu_inst_valid, ifu_inst, ifu_pc);
    end
    ifu_inst_ready = 1'b1;
    tick;
    ifu_inst_ready = 1'b0;
    tests_run++;
    if (ifu_inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
      tests_failed++;
      $display("FAIL basic_next_req: got iv=%b rv=%b addr %h expected iv=0 rv=1 addr 80000004",
               ifu_inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_req_stall;
    do_reset;
    tick;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || ifu_inst_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got rv=%b addr %h iv=%b expected rv=1 addr 80000000 iv=0",
                 i, imem_req_valid, imem_req_addr, ifu_inst_valid);
      end
      tick;
    end
    fetch_to_valid(32'h0000_0013);
    tests_run++;
    if (ifu_inst_valid !== 1'b1 || ifu_inst !== 32'h0000_0013 || ifu_pc !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL stall_after: got v=%b inst %h pc %h expected v=1 inst 00000013 pc 80000000",
               ifu_inst_valid, ifu_inst, ifu_pc);
    end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    tick;
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready  = 1'b0;
    exu_redirect    = 1'b1;
    exu_redirect_pc = 32'h8000_0100;
    tick;
    exu_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({imem_req_valid, ifu_inst_valid} !== 2'b00) begin
        tests_failed++;
        $display("FAIL redir_wait_idle[%0d]: got %b expected 00", i, {imem_req_valid, ifu_inst_valid});
      end
      if (i == 0) tick;
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick;
    imem_rsp_valid = 1'b0;
    tests_run++;
    if (ifu_inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      tests_failed++;
      $display("FAIL redir_wait_drop: got iv=%b rv=%b addr %h expected iv=0 rv=1 addr 80000100",
               ifu_inst_valid, imem_req_valid, imem_req_addr);
    end
    fetch_to_valid(32'h0050_0293);
    tests_run++;
    if (ifu_inst !== 32'h0050_0293 || ifu_pc !== 32'h8000_0100) begin
      tests_failed++;
      $display("FAIL redir_wait_next: got inst %h pc %h expected 00500293 80000100", ifu_inst, ifu_pc);
    end
  endtask

  task automatic test_valid_hold;
    do_reset;
    tick;
    fetch_to_valid(32'h00A0_0513);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ifu_inst_valid !== 1'b1 || ifu_inst !== 32'h00A0_0513 || ifu_pc !== 32'h8000_0000) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got v=%b inst %h pc %h expected v=1 inst 00a00513 pc 80000000",
                 i, ifu_inst_valid, ifu_inst, ifu_pc);
      end
      tick;
    end
    exu_redirect    = 1'b1;
    exu_redirect_pc = 32'h8000_0200;
    ifu_inst_ready  = 1'b1;
    tick;
    exu_redirect   = 1'b0;
    ifu_inst_ready = 1'b0;
    tests_run++;
    if (ifu_inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      tests_failed++;
      $display("FAIL hold_redirect: got iv=%b rv=%b addr %h expected iv=0 rv=1 addr 80000200",
               ifu_inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_halt;
    do_reset;
    tick;
    fetch_to_valid(32'h0020_0113);
    ifu_halt = 1'b1;
    tick;
    tests_run++;
    if (ifu_inst_valid !== 1'b1 || ifu_inst !== 32'h0020_0113) begin
      tests_failed++;
      $display("FAIL halt_keep: got v=%b inst %h expected v=1 inst 00200113", ifu_inst_valid, ifu_inst);
    end
    ifu_inst_ready = 1'b1;
    tick;
    ifu_inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({imem_req_valid, ifu_inst_valid} !== 2'b00) begin
        tests_failed++;
        $display("FAIL halt_quiet[%0d]: got %b expected 00", i, {imem_req_valid, ifu_inst_valid});
      end
      tick;
    end
    ifu_halt = 1'b0;
    tick;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
      tests_failed++;
      $display("FAIL halt_resume: got v=%b addr %h expected v=1 addr 80000004", imem_req_valid, imem_req_addr);
    end
    ifu_halt = 1'b1;
    tick;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_withdraw: got %b expected 0", imem_req_valid);
    end
    ifu_halt = 1'b0;
    tick;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
      tests_failed++;
      $display("FAIL halt_reissue: got v=%b addr %h expected v=1 addr 80000004", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_wait;
    do_reset;
    tick;
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    rst_b = 1'b0;
    tick;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_C0DE;
    tests_run++;
    if ({imem_req_valid, ifu_inst_valid} !== 2'b00 || ifu_pc !== PC_RST || ifu_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstwait_reset: got rv=%b iv=%b pc %h inst %h expected 0 0 %h 00000000",
               imem_req_valid, ifu_inst_valid, ifu_pc, ifu_inst, PC_RST);
    end
    tick;
    rst_b = 1'b1;
    imem_rsp_data = 32'h0BAD_F00D;
    tests_run++;
    if ({imem_req_valid, ifu_inst_valid} !== 2'b00 || ifu_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstwait_stale: got rv=%b iv=%b inst %h expected 0 0 00000000",
               imem_req_valid, ifu_inst_valid, ifu_inst);
    end
    tick;
    imem_rsp_valid = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || ifu_inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstwait_req: got rv=%b addr %h iv=%b expected rv=1 addr 80000000 iv=0",
               imem_req_valid, imem_req_addr, ifu_inst_valid);
    end
    fetch_to_valid(32'h0030_0193);
    tests_run++;
    if (ifu_inst_valid !== 1'b1 || ifu_inst !== 32'h0030_0193 || ifu_pc !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL rstwait_inst: got v=%b inst %h pc %h expected v=1 inst 00300193 pc 80000000",
               ifu_inst_valid, ifu_inst, ifu_pc);
    end
  endtask

  task automatic test_redirect_accept;
    do_reset;
    tick;
    imem_req_ready  = 1'b1;
    exu_redirect    = 1'b1;
    exu_redirect_pc = 32'h8000_0302;
    tick;
    clear_inputs;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick;
    imem_rsp_valid = 1'b0;
    tests_run++;
    if (ifu_inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
      tests_failed++;
      $display("FAIL redir_accept: got iv=%b rv=%b addr %h expected iv=0 rv=1 addr 80000300",
               ifu_inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_rsp_same;
    do_reset;
    tick;
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b1;
    imem_rsp_data   = 32'h2222_2222;
    exu_redirect    = 1'b1;
    exu_redirect_pc = 32'h8000_0400;
    tick;
    clear_inputs;
    tests_run++;
    if (ifu_inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400) begin
      tests_failed++;
      $display("FAIL redir_rsp_same: got iv=%b rv=%b addr %h expected iv=0 rv=1 addr 80000400",
               ifu_inst_valid, imem_req_valid, imem_req_addr);
    end
    fetch_to_valid(32'h0070_0393);
    tests_run++;
    if (ifu_inst_valid !== 1'b1 || ifu_inst !== 32'h0070_0393 || ifu_pc !== 32'h8000_0400) begin
      tests_failed++;
      $display("FAIL redir_rsp_next: got v=%b inst %h pc %h expected v=1 inst 00700393 pc 80000400",
               ifu_inst_valid, ifu_inst, ifu_pc);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    tick;
    exu_redirect    = 1'b1;
    exu_redirect_pc = 32'hFFFF_FFFF;
    tick;
    exu_redirect = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_align: got v=%b addr %h expected v=1 addr fffffffc", imem_req_valid, imem_req_addr);
    end
    fetch_to_valid(32'h0060_0313);
    tests_run++;
    if (ifu_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_pc: got %h expected fffffffc", ifu_pc);
    end
    ifu_inst_ready = 1'b1;
    tick;
    ifu_inst_ready = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL wrap_next: got v=%b addr %h expected v=1 addr 00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, out_addr, prev_inst, prev_pc, prev_addr, rpc;
    bit          outstanding, hold_inst, hold_req, accept, deliver;
    int unsigned dly, stall, delivered, quiet;
    do_reset;
    exp_pc      = PC_RST;
    out_addr    = '0;
    prev_inst   = '0;
    prev_pc     = '0;
    prev_addr   = '0;
    outstanding = 1'b0;
    hold_inst   = 1'b0;
    hold_req    = 1'b0;
    dly         = 0;
    stall       = 0;
    delivered   = 0;
    quiet       = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_b = 1'b0;
        clear_inputs;
        if (outstanding) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(out_addr);
          outstanding    = 1'b0;
        end
        tick;
        imem_rsp_valid = 1'b0;
        tick;
        tick;
        rst_b     = 1'b1;
        exp_pc    = PC_RST;
        hold_inst = 1'b0;
        hold_req  = 1'b0;
        quiet     = 2;
        stall     = 0;
        tests_run++;
        if ({imem_req_valid, ifu_inst_valid} !== 2'b00 || ifu_pc !== PC_RST) begin
          tests_failed++;
          $display("FAIL rand_reset: got rv=%b iv=%b pc %h expected 0 0 %h",
                   imem_req_valid, ifu_inst_valid, ifu_pc, PC_RST);
        end
        continue;
      end

      imem_req_ready = ($urandom_range(0, 2) != 0);
      ifu_inst_ready = 1'($urandom_range(0, 1));
      exu_redirect   = (quiet == 0) && ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc[31:4] = '1;
      else rpc[31:24] = 8'h80;
      exu_redirect_pc = rpc;
      if (quiet != 0) quiet--;
      imem_rsp_valid = 1'b0;
      if (outstanding) begin
        if (dly == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(out_addr);
        end else begin
          dly--;
        end
      end

      if (hold_inst) begin
        tests_run++;
        if (ifu_inst_valid !== 1'b1 || ifu_inst !== prev_inst || ifu_pc !== prev_pc) begin
          tests_failed++;
          $display("FAIL rand_inst_hold @%0d: got v=%b inst %h pc %h expected v=1 inst %h pc %h",
                   cyc, ifu_inst_valid, ifu_inst, ifu_pc, prev_inst, prev_pc);
        end
      end
      if (hold_req) begin
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
          tests_failed++;
          $display("FAIL rand_req_hold @%0d: got v=%b addr %h expected v=1 addr %h",
                   cyc, imem_req_valid, imem_req_addr, prev_addr);
        end
      end

      accept = imem_req_valid && imem_req_ready;
      if (accept) begin
        tests_run++;
        if (outstanding || imem_req_addr[1:0] != 2'b00) begin
          tests_failed++;
          $display("FAIL rand_req_issue @%0d: got outstanding=%b addr %h expected outstanding=0 aligned addr",
                   cyc, outstanding, imem_req_addr);
        end
      end
      if (imem_rsp_valid) outstanding = 1'b0;
      if (accept) begin
        outstanding = 1'b1;
        dly         = $urandom_range(0, 2);
        out_addr    = imem_req_addr;
      end

      deliver = ifu_inst_valid && ifu_inst_ready && !exu_redirect;
      if (deliver) begin
        tests_run++;
        if (ifu_pc !== exp_pc || ifu_inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL rand_deliver @%0d: got pc %h inst %h expected pc %h inst %h",
                   cyc, ifu_pc, ifu_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
        stall = 0;
      end else begin
        stall++;
      end
      if (exu_redirect) exp_pc = {rpc[31:2], 2'b00};

      hold_inst = ifu_inst_valid && !ifu_inst_ready && !exu_redirect;
      prev_inst = ifu_inst;
      prev_pc   = ifu_pc;
      hold_req  = imem_req_valid && !imem_req_ready && !exu_redirect;
      prev_addr = imem_req_addr;

      if (stall > 200) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rand_progress @%0d: got %0d idle cycles expected at most 200", cyc, stall);
        break;
      end
      tick;
    end
    clear_inputs;
    tests_run++;
    if (delivered < 100) begin
      tests_failed++;
      $display("FAIL rand_delivered: got %0d instructions expected at least 100", delivered);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    clear_inputs;
    test_reset;
    test_basic;
    test_req_stall;
    test_redirect_wait;
    test_valid_hold;
    test_halt;
    test_reset_wait;
    test_redirect_accept;
    test_redirect_rsp_same;
    test_wrap;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
